meta_rr_arbiter: RTL and testbench
==================================

Name: meta_rr_arbiter

Overview:
- N-to-1 round-robin arbiter for generic valid/ready/data meta streams.
- Shares one downstream meta consumer between several requesters, e.g. RDMA command/response queues feeding one request port.
- Registered output stage: full throughput, one cycle of latency, and the granted source index is carried alongside the data.
- Sits between requester meta channels and a single consumer inside the RoCE stack shell.

Parameters:
- N_SRC, 4: number of requester inputs, 2..16.
- DATA_BITS, 64: width of one meta word; matches the default meta interface type width.
- ID_BITS, $clog2(N_SRC): width of the source index output (derived localparam, not overridable).
- BURST, 4: maximum consecutive beats per grant. Used only with META_ARB_BURST_EN; range 1..255.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_meta_valid  in  N_SRC  per-requester valid.
- s_meta_ready  out  N_SRC  per-requester ready (one-hot or zero).
- s_meta_data  in  N_SRC*DATA_BITS  requester i occupies bits [i*DATA_BITS +: DATA_BITS].
- m_meta_valid  out  1  output valid (registered).
- m_meta_ready  in  1  downstream ready.
- m_meta_data  out  DATA_BITS  output word (registered).
- m_meta_id  out  ID_BITS  index of the requester that supplied m_meta_data (registered).

Behaviour:
- Interface: one clock, aclk; reset is synchronous and active-high, port named reset. No other clock or reset domains.
- Reset values: m_meta_valid=0, m_meta_data=0, m_meta_id=0, last_grant=N_SRC-1 (so input 0 has top priority after reset), burst_cnt=0. s_meta_ready is combinational and is 0 while reset is high.
- load_en = !m_meta_valid || m_meta_ready.
- Grant:
  - Combinational.
  - Among the asserted s_meta_valid bits, pick the first index found searching cyclically from last_grant+1 (mod N_SRC).
  - grant_vld = |s_meta_valid.
- s_meta_ready[i] = load_en && grant_vld && (grant==i).
  - Ready depends on valid; valid never depends on ready.
  - At most one ready bit is high per cycle.
- Transfer on edge when load_en && grant_vld:
  - m_meta_data <= s_meta_data[grant].
  - m_meta_id <= grant.
  - m_meta_valid <= 1.
  - last_grant <= grant.
- When load_en && !grant_vld: m_meta_valid <= 0; data and id hold their values.
- When !load_en (output stalled): all output registers hold; no input is accepted.
- Latency: input handshake at cycle t gives m_meta_valid at t+1. Sustained throughput is 1 beat/cycle with m_meta_ready held high.
- Fairness: with all N_SRC inputs continuously valid, grants rotate 0,1,..,N_SRC-1,0,...
- A requester may drop valid without a handshake; the grant is recomputed every cycle with no lock.
- Output AXI-stream-style stability: while m_meta_valid && !m_meta_ready, data and id do not change.
- Simultaneous output consume and new accept in the same cycle: back-to-back, no bubble.
- Reset mid-transfer: a pending output beat is discarded; last_grant returns to N_SRC-1.

Optional Feature:
- Macro: META_ARB_BURST_EN.
- Defined:
  - burst_cnt (8 bits) counts accepted beats from the current holder.
  - If s_meta_valid[last_grant] is high and burst_cnt < BURST, grant stays with last_grant instead of rotating.
  - burst_cnt resets to 1 when a grant moves to a new source and increments on each same-source accept.
  - The holder dropping valid releases the grant immediately.
  - BURST=1 behaves identically to the macro being undefined.
- Undefined: pure per-beat round-robin; no burst_cnt register.

Decomposition:
- Shared package (roceTypes or a new meta_arb_pkg):
  - localparam META_ARB_MAX_SRC=16.
  - typedef meta_arb_id_t (logic [3:0]).
- Sub-module rr_prio_select (purely combinational), parameter N:
  - Inputs: req[N], last[$clog2(N)].
  - Outputs: gnt_idx, gnt_vld.
  - Implemented as a masked find-first with fallback to an unmasked find-first.
- The top level holds the output register, last_grant and, under the macro, burst_cnt.
- A thin wrapper binds metaIntf.s[N] / metaIntf.m onto the flat ports.

Test Plan:
- Reset then single source: hold s_meta_valid=4'b0100 with data 0xA5 and m_meta_ready=1.
  - Expect s_meta_ready=4'b0100 in the same cycle.
  - Next cycle expect m_meta_valid=1, data=0xA5, id=2.
- All four valid, ready=1, for 8 cycles: expect the id sequence 0,1,2,3,0,1,2,3 with no bubbles.
- Backpressure: m_meta_ready=0 for 5 cycles while all sources are valid.
  - Expect s_meta_ready=0 throughout and output data/id stable.
  - On ready=1, expect the next grant to be (last id+1) mod 4.
- Sparse: sources 1 and 3 valid, last_grant=1.
  - Expect grant 3, then 1, then 3.
  - Sources 0 and 2 are never granted.
- Reset asserted while m_meta_valid=1 and m_meta_ready=0: expect m_meta_valid=0 the next cycle and the first grant after reset to go to source 0.
- With META_ARB_BURST_EN, BURST=3, all sources valid: expect ids 0,0,0,1,1,1,2,2,2.
  - With source 1 dropping valid after 1 beat, expect 0,0,0,1,2,2,2.

Source files
------------

// File: rtl/meta_arb_pkg.sv
// Shared constants and types for the meta-stream round-robin arbiter.
package meta_arb_pkg;

   localparam int unsigned META_ARB_MAX_SRC = 16;

   typedef logic [3:0] meta_arb_id_t;

endpackage

// File: rtl/meta_rr_arbiter_prio.sv
// rr_prio_select: combinational round-robin pick, masked find-first above
// `last` with fallback to an unmasked find-first.
module rr_prio_select
   import meta_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 gnt_vld
);

   localparam int W = $clog2(N);

   logic [N-1:0] upper_req;
   logic         m_found;
   logic         u_found;
   logic [W-1:0] m_idx;
   logic [W-1:0] u_idx;

   always_comb begin
      upper_req = '0;
      m_found   = 1'b0;
      u_found   = 1'b0;
      m_idx     = '0;
      u_idx     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         upper_req[i] = req[i] && (i > 32'(last));
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (upper_req[i] && !m_found) begin
            m_found = 1'b1;
            m_idx   = W'(i);
         end
         if (req[i] && !u_found) begin
            u_found = 1'b1;
            u_idx   = W'(i);
         end
      end
      gnt_vld = u_found;
      gnt_idx = m_found ? m_idx : u_idx;
   end

endmodule

// File: rtl/meta_rr_arbiter.sv
// N-to-1 round-robin arbiter for valid/ready/data meta streams with a
// registered output stage. Define META_ARB_BURST_EN to allow up to BURST
// consecutive beats per grant.
module meta_rr_arbiter
   import meta_arb_pkg::*;
#(
   parameter int N_SRC     = 4,
   parameter int DATA_BITS = 64,
   parameter int BURST     = 4
) (
   input  logic                       aclk,
   input  logic                       reset,
   input  logic [N_SRC-1:0]           s_meta_valid,
   output logic [N_SRC-1:0]           s_meta_ready,
   input  logic [N_SRC*DATA_BITS-1:0] s_meta_data,
   output logic                       m_meta_valid,
   input  logic                       m_meta_ready,
   output logic [DATA_BITS-1:0]       m_meta_data,
   output logic [$clog2(N_SRC)-1:0]   m_meta_id
);

   localparam int ID_BITS = $clog2(N_SRC);

   if (N_SRC < 2 || N_SRC > int'(META_ARB_MAX_SRC) || BURST < 1 || BURST > 255) begin : g_bad_cfg
      $error("meta_rr_arbiter: parameter out of range");
   end

   logic                 m_valid_q;
   logic [DATA_BITS-1:0] m_data_q;
   logic [ID_BITS-1:0]   m_id_q;
   logic [ID_BITS-1:0]   last_grant_q;
   logic [ID_BITS-1:0]   rr_idx;
   logic                 grant_vld;
   logic [ID_BITS-1:0]   grant;
   logic                 load_en;
   logic                 xfer;

   rr_prio_select #(.N(N_SRC)) u_prio (
      .req     (s_meta_valid),
      .last    (last_grant_q),
      .gnt_idx (rr_idx),
      .gnt_vld (grant_vld)
   );

`ifdef META_ARB_BURST_EN
   logic [7:0] burst_cnt_q;
   logic       hold;

   // A zero count means no holder yet (after reset), so rotation applies.
   assign hold  = s_meta_valid[last_grant_q] && (burst_cnt_q != 8'd0)
                  && (32'(burst_cnt_q) < BURST);
   assign grant = hold ? last_grant_q : rr_idx;

   always_ff @(posedge aclk) begin
      if (reset) begin
         burst_cnt_q <= '0;
      end else if (xfer) begin
         if (grant == last_grant_q && burst_cnt_q != 8'd0) begin
            if (burst_cnt_q != 8'hFF) burst_cnt_q <= burst_cnt_q + 8'd1;
         end else begin
            burst_cnt_q <= 8'd1;
         end
      end
   end
`else
   assign grant = rr_idx;
`endif

   assign load_en = !m_valid_q || m_meta_ready;
   assign xfer    = load_en && grant_vld;

   always_comb begin
      s_meta_ready = '0;
      if (!reset && xfer) s_meta_ready[grant] = 1'b1;
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_id_q       <= '0;
         last_grant_q <= ID_BITS'(N_SRC - 1);
      end else if (xfer) begin
         m_valid_q    <= 1'b1;
         m_data_q     <= s_meta_data[grant*DATA_BITS +: DATA_BITS];
         m_id_q       <= grant;
         last_grant_q <= grant;
      end else if (load_en) begin
         m_valid_q    <= 1'b0;
      end
   end

   assign m_meta_valid = m_valid_q;
   assign m_meta_data  = m_data_q;
   assign m_meta_id    = m_id_q;

endmodule

// File: tb/tb_meta_rr_arbiter.sv
// Directed self-checking bench for meta_rr_arbiter (N_SRC=4, BURST=3).
module tb_meta_rr_arbiter;

   logic         aclk = 1'b0;
   logic         reset;
   logic [3:0]   s_meta_valid;
   logic [3:0]   s_meta_ready;
   logic [255:0] s_meta_data;
   logic         m_meta_valid;
   logic         m_meta_ready;
   logic [63:0]  m_meta_data;
   logic [1:0]   m_meta_id;

   int checks = 0;
   int errors = 0;

   meta_rr_arbiter #(.N_SRC(4), .DATA_BITS(64), .BURST(3)) dut (
      .aclk         (aclk),
      .reset        (reset),
      .s_meta_valid (s_meta_valid),
      .s_meta_ready (s_meta_ready),
      .s_meta_data  (s_meta_data),
      .m_meta_valid (m_meta_valid),
      .m_meta_ready (m_meta_ready),
      .m_meta_data  (m_meta_data),
      .m_meta_id    (m_meta_id)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic set_data(input logic [63:0] base);
      for (int i = 0; i < 4; i++) s_meta_data[i*64 +: 64] = base + 64'(i);
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      s_meta_valid = '0;
      m_meta_ready = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      s_meta_valid = 4'b1111;
      m_meta_ready = 1'b1;
      set_data(64'h100);
      tick();
      checks++;
      if (s_meta_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_ready got %b want 0000", s_meta_ready);
      end
      checks++;
      if (m_meta_valid !== 1'b0 || m_meta_data !== 64'd0 || m_meta_id !== 2'd0) begin
         errors++; $display("FAIL reset_out got v=%b d=%h id=%0d want v=0 d=0 id=0",
                            m_meta_valid, m_meta_data, m_meta_id);
      end
   endtask

   task automatic test_single();
      do_reset();
      s_meta_valid = 4'b0100;
      s_meta_data  = '0;
      s_meta_data[2*64 +: 64] = 64'hA5;
      #1;
      checks++;
      if (s_meta_ready !== 4'b0100) begin
         errors++; $display("FAIL single_ready got %b want 0100", s_meta_ready);
      end
      tick();
      checks++;
      if (m_meta_valid !== 1'b1 || m_meta_data !== 64'hA5 || m_meta_id !== 2'd2) begin
         errors++; $display("FAIL single_out got v=%b d=%h id=%0d want v=1 d=a5 id=2",
                            m_meta_valid, m_meta_data, m_meta_id);
      end
   endtask

   task automatic test_rotate();
      do_reset();
      set_data(64'h100);
      s_meta_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         checks++;
         if (s_meta_ready !== 4'(1 << (k % 4))) begin
            errors++; $display("FAIL rotate_ready[%0d] got %b want %b", k, s_meta_ready, 4'(1 << (k % 4)));
         end
         tick();
         checks++;
         if (m_meta_valid !== 1'b1 || m_meta_id !== 2'(k % 4) || m_meta_data !== 64'h100 + 64'(k % 4)) begin
            errors++; $display("FAIL rotate_out[%0d] got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                               k, m_meta_valid, m_meta_id, m_meta_data, k % 4, 64'h100 + 64'(k % 4));
         end
      end
   endtask

   // Continues from test_rotate: last accepted id is 3.
   task automatic test_backpressure();
      m_meta_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (s_meta_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_ready[%0d] got %b want 0000", k, s_meta_ready);
         end
         tick();
         checks++;
         if (m_meta_valid !== 1'b1 || m_meta_id !== 2'd3 || m_meta_data !== 64'h103) begin
            errors++; $display("FAIL bp_hold[%0d] got v=%b id=%0d d=%h want v=1 id=3 d=103",
                               k, m_meta_valid, m_meta_id, m_meta_data);
         end
      end
      m_meta_ready = 1'b1;
      #1;
      checks++;
      if (s_meta_ready !== 4'b0001) begin
         errors++; $display("FAIL bp_release_ready got %b want 0001", s_meta_ready);
      end
      tick();
      checks++;
      if (m_meta_id !== 2'd0 || m_meta_data !== 64'h100) begin
         errors++; $display("FAIL bp_release_id got id=%0d d=%h want id=0 d=100", m_meta_id, m_meta_data);
      end
   endtask

   // Continues with last grant 0: first pick is 1, then 3,1,3.
   task automatic test_sparse();
      logic [1:0] exp_id [4];
      exp_id = '{2'd1, 2'd3, 2'd1, 2'd3};
      s_meta_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (s_meta_ready !== 4'(1 << exp_id[k])) begin
            errors++; $display("FAIL sparse_ready[%0d] got %b want %b", k, s_meta_ready, 4'(1 << exp_id[k]));
         end
         tick();
         checks++;
         if (m_meta_id !== exp_id[k] || m_meta_data !== 64'h100 + 64'(exp_id[k])) begin
            errors++; $display("FAIL sparse_id[%0d] got %0d want %0d", k, m_meta_id, exp_id[k]);
         end
      end
   endtask

   task automatic test_idle();
      s_meta_valid = 4'b0000;
      tick();
      checks++;
      if (m_meta_valid !== 1'b0 || m_meta_id !== 2'd3 || m_meta_data !== 64'h103) begin
         errors++; $display("FAIL idle_out got v=%b id=%0d d=%h want v=0 id=3 d=103",
                            m_meta_valid, m_meta_id, m_meta_data);
      end
   endtask

   task automatic test_reset_mid();
      s_meta_valid = 4'b0100;
      m_meta_ready = 1'b0;
      tick();
      checks++;
      if (m_meta_valid !== 1'b1 || m_meta_id !== 2'd2) begin
         errors++; $display("FAIL mid_setup got v=%b id=%0d want v=1 id=2", m_meta_valid, m_meta_id);
      end
      reset        = 1'b1;
      s_meta_valid = 4'b1111;
      tick();
      checks++;
      if (m_meta_valid !== 1'b0) begin
         errors++; $display("FAIL mid_valid got %b want 0", m_meta_valid);
      end
      reset        = 1'b0;
      m_meta_ready = 1'b1;
      #1;
      checks++;
      if (s_meta_ready !== 4'b0001) begin
         errors++; $display("FAIL mid_first_ready got %b want 0001", s_meta_ready);
      end
      tick();
      checks++;
      if (m_meta_valid !== 1'b1 || m_meta_id !== 2'd0) begin
         errors++; $display("FAIL mid_first_id got v=%b id=%0d want v=1 id=0", m_meta_valid, m_meta_id);
      end
   endtask

`ifdef META_ARB_BURST_EN
   task automatic test_burst();
      logic [1:0] exp_a [9];
      logic [1:0] exp_b [7];
      logic [3:0] vld_b [7];
      exp_a = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
      exp_b = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2};
      vld_b = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hD, 4'hD, 4'hD};
      do_reset();
      s_meta_valid = 4'b1111;
      for (int k = 0; k < 9; k++) begin
         tick();
         checks++;
         if (m_meta_id !== exp_a[k]) begin
            errors++; $display("FAIL burst_all[%0d] got %0d want %0d", k, m_meta_id, exp_a[k]);
         end
      end
      do_reset();
      for (int k = 0; k < 7; k++) begin
         s_meta_valid = vld_b[k];
         tick();
         checks++;
         if (m_meta_id !== exp_b[k]) begin
            errors++; $display("FAIL burst_drop[%0d] got %0d want %0d", k, m_meta_id, exp_b[k]);
         end
      end
   endtask
`endif

   initial begin
      reset        = 1'b1;
      s_meta_valid = '0;
      s_meta_data  = '0;
      m_meta_ready = 1'b0;
      #1;
      test_reset();
      test_single();
      test_rotate();
      test_backpressure();
      test_sparse();
      test_idle();
      test_reset_mid();
`ifdef META_ARB_BURST_EN
      test_burst();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
